// File: rtl/bus_master_if.sv
// Request/acknowledge register-access bus between an initiator and a slave.
// Four-phase handshake per beat: req up, ack up, req down, ack down.
interface bus_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   logic              req;
   logic              cmd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, cmd, addr, wdata, input ack, rdata);
   modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/bus_master.sv
// Bus initiator: runs single/multi-beat read or write commands over the req/ack bus
// with a per-phase timeout so a dead slave cannot hang the caller.
module bus_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              op_cmd,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [LEN_W-1:0]  op_len,
   input  logic              wd_valid,
   input  logic [DATA_W-1:0] wd_data,
   output logic              wd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   bus_master_if.master      bus
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] REQ   = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic              cmd_q,      cmd_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [DATA_W-1:0] wdata_q,    wdata_d;
   logic [LEN_W-1:0]  len_q,      len_d;
   logic              req_q,      req_d;
   logic [TMO_W-1:0]  tmo_q,      tmo_d;
   logic              abort_q,    abort_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              err_q,      err_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q,  rd_data_d;
   logic              tmo_hit;

   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

   // Next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      len_d      = len_q;
      req_d      = req_q;
      tmo_d      = tmo_q;
      abort_d    = abort_q;
      busy_d     = busy_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               cmd_d   = op_cmd;
               addr_d  = op_addr;
               len_d   = op_len;
               busy_d  = 1'b1;
               abort_d = 1'b0;
               tmo_d   = '0;
               if (op_cmd) begin
                  state_d = FETCH;
               end else begin
                  state_d = REQ;
                  req_d   = 1'b1;
               end
            end
         end
         FETCH: begin
            if (wd_valid) begin
               wdata_d = wd_data;
               req_d   = 1'b1;
               tmo_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // ack wins over a timeout landing on the same edge
            if (bus.ack) begin
               req_d   = 1'b0;
               tmo_d   = '0;
               state_d = DRAIN;
               if (!cmd_q) begin
                  rd_data_d  = bus.rdata;
                  rd_valid_d = 1'b1;
               end
            end else if (tmo_hit) begin
               req_d   = 1'b0;
               abort_d = 1'b1;
               tmo_d   = '0;
               state_d = DRAIN;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         DRAIN: begin
            if (!bus.ack) begin
               if (abort_q || (len_q == '0)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  err_d   = abort_q;
               end else begin
                  len_d  = len_q - LEN_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
                  tmo_d  = '0;
                  if (cmd_q) begin
                     state_d = FETCH;
                  end else begin
                     state_d = REQ;
                     req_d   = 1'b1;
                  end
               end
            end else if (tmo_hit) begin
               // ack stuck high: give up on the rest of the command
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         cmd_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         len_q      <= '0;
         req_q      <= 1'b0;
         tmo_q      <= '0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         len_q      <= len_d;
         req_q      <= req_d;
         tmo_q      <= tmo_d;
         abort_q    <= abort_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign wd_ready  = (state_q == FETCH);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign bus.req   = req_q;
   assign bus.cmd   = cmd_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;

endmodule

// File: doc/bus_master.md
# bus_master

Initiator for the req/ack register-access bus: takes a single- or multi-beat read/write command from local control logic, drives req/cmd/addr/wdata toward a slave, waits for ack, returns read data beat by beat, and signals completion. Each beat is a full four-phase handshake. A per-beat timeout prevents a dead or missing slave from hanging the caller.

## Interface
- ADDR_W, 32, bus address width; slave word index
- DATA_W, 32, bus data width
- LEN_W, 8, width of op_len; burst = op_len+1 beats (1..2^LEN_W)
- TIMEOUT, 16, cycles allowed per handshake phase before abort (≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- arst_n  in  1  asynchronous reset, active-low
- start  in  1  command strobe; sampled only when busy=0
- op_cmd  in  1  1=write, 0=read
- op_addr  in  ADDR_W  first beat address
- op_len  in  LEN_W  beats minus one
- wd_valid  in  1  write data available
- wd_data  in  DATA_W  write data for next beat
- wd_ready  out  1  master accepts wd_data this cycle
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DATA_W  read data of completed beat
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- err  out  1  one-cycle pulse with done if command aborted by timeout
- req  out  1  bus request
- cmd  out  1  bus command, 1=write
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- ack  in  1  bus acknowledge
- rdata  in  DATA_W  bus read data, valid while ack=1

## Operation
- Reset (arst_n=0, immediate): state IDLE; all outputs 0; beat and timeout counters 0.
- States: IDLE, FETCH, REQ, DRAIN.
- IDLE: start=1 → latch op_cmd, op_addr, op_len; busy←1; write → FETCH, read → REQ with req←1, cmd←0, addr←op_addr.
- FETCH (writes only): wd_ready=1 (combinational from state). On wd_valid=1: wdata←wd_data, req←1, cmd←1 → REQ. No timeout in FETCH.
- REQ: req, cmd, addr, wdata held stable. On ack=1: req←0; read beat → rd_data←rdata, rd_valid pulse; → DRAIN.
- DRAIN: wait for ack=0. Then if beats remain: addr←addr+1 (mod 2^ADDR_W), next beat (FETCH for write; REQ with req←1 for read). Else → IDLE, done pulse, busy←0.
- Timeout: counter clears on each REQ/DRAIN entry, increments each cycle there. Reaching TIMEOUT in REQ: req←0, set abort flag, → DRAIN. Reaching TIMEOUT in DRAIN (ack stuck high): → IDLE. Aborted command ends in IDLE with done=1 and err=1; remaining beats dropped.
- start while busy=1 ignored, no queueing. wd_valid outside FETCH ignored.
- The slave re-executes a request on every edge req is high, so a write beat may be written twice at the same address/data (idempotent) and a read beat read twice; rd_data always holds the value present on the ack-observed edge.

## Timing
- Edge 0 accepts start; read req=1 after edge 0. Write req=1 one edge after wd_valid seen in FETCH.
- Registered slave: ack=1 after edge 1; master sees ack on edge 2, drops req, captures rdata, rd_valid=1 for cycle after edge 2.
- ack=0 after edge 3; master sees it on edge 4: next read req=1 after edge 4, or done=1 for the cycle after edge 4.
- Single read: done 4 cycles after accept edge; read burst of N beats: 4N cycles. Write beat adds ≥1 FETCH cycle.
- busy=1 from accept edge until the edge on which done is asserted (busy=0 in the done cycle).
- A new start may be accepted in the done cycle.
- Reset mid-beat: req drops immediately; no done, no err.

## Test plan
- Single write op_addr=5, wd_data=0xDEADBEEF, then single read addr 5 → bus write seen at addr 5; rd_valid once, rd_data=0xDEADBEEF; done pulse, err=0, read done 4 cycles after accept.
- Write burst op_addr=10, op_len=3, data 0x11,0x22,0x33,0x44 with wd_valid gaps of 2 cycles; read back → addr 10..13 hold data in order; 4 rd_valid pulses with 0x11..0x44; one done.
- Address wrap: ADDR_W=4 model, op_addr=15, op_len=1 → beats at addr 15 then 0.
- No slave (ack tied 0), TIMEOUT=16, read → req drops after 16 cycles in REQ; done=1, err=1, no rd_valid; busy clears.
- ack stuck 1 after first beat, op_len=2 → DRAIN timeout; done=err=1, no further req.
- start pulsed during busy, and arst_n asserted mid-REQ → second start ignored; after reset all outputs 0, next start runs cleanly.
